// File: rtl/mips_control_fsm.sv
// Multi-cycle control unit for the 32-bit MIPS datapath.
// Sequences each instruction through fetch/decode/exec/mem/writeback, drives the datapath
// strobes and mux selects, flags unsupported instructions and counts retired ones.
module mips_control_fsm #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [5:0]       opcode,
  input  logic [5:0]       funct,
  input  logic             alu_zero,
  input  logic             mem_ready,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_sel,
  output logic             alu_src,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic             mem_read,
  output logic             mem_write,
  output logic [2:0]       state,
  output logic             illegal,
  output logic [CNT_W-1:0] instr_count
);

  typedef enum logic [2:0] {
    StFetch  = 3'd0,
    StDecode = 3'd1,
    StExec   = 3'd2,
    StMem    = 3'd3,
    StWb     = 3'd4,
    StHalt   = 3'd7
  } state_e;

  localparam logic [5:0] OpRtype = 6'b000000;
  localparam logic [5:0] OpLw    = 6'b100011;
  localparam logic [5:0] OpSw    = 6'b101011;
  localparam logic [5:0] OpBeq   = 6'b000100;

  localparam logic [5:0] FnAdd = 6'b100000;
  localparam logic [5:0] FnSub = 6'b100010;
  localparam logic [5:0] FnAnd = 6'b100100;
  localparam logic [5:0] FnOr  = 6'b100101;

  state_e           state_q, state_d;
  logic [5:0]       opcode_q, funct_q;
  logic             illegal_q, illegal_d;
  logic [CNT_W-1:0] count_q;
  logic             retire;

  logic dec_legal;
  logic is_rtype, is_lw, is_sw, is_beq;

  function automatic logic rtype_fn_ok(input logic [5:0] fn);
    return (fn == FnAdd) || (fn == FnSub) || (fn == FnAnd) || (fn == FnOr);
  endfunction

  // Legality is judged on the live fields in DECODE; later states use the latched copies.
  assign dec_legal = ((opcode == OpRtype) && rtype_fn_ok(funct)) || (opcode == OpLw) ||
                     (opcode == OpSw) || (opcode == OpBeq);

  assign is_rtype = (opcode_q == OpRtype) && rtype_fn_ok(funct_q);
  assign is_lw    = (opcode_q == OpLw);
  assign is_sw    = (opcode_q == OpSw);
  assign is_beq   = (opcode_q == OpBeq);

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign instr_count = count_q;

  // State register, latched instruction fields, sticky illegal flag and retire counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= StFetch;
      opcode_q  <= 6'd0;
      funct_q   <= 6'd0;
      illegal_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      illegal_q <= illegal_d;
      if (state_q == StDecode) begin
        opcode_q <= opcode;
        funct_q  <= funct;
      end
      if (retire) begin
        count_q <= count_q + CNT_W'(1);
      end
    end
  end

  // Next-state logic; retire marks the edge that leaves an instruction's last state.
  always_comb begin
    state_d   = state_q;
    illegal_d = illegal_q;
    retire    = 1'b0;
    unique case (state_q)
      StFetch: state_d = StDecode;
      StDecode: begin
        if (dec_legal) begin
          state_d = StExec;
        end else begin
          state_d   = StHalt;
          illegal_d = 1'b1;
        end
      end
      StExec: begin
        if (is_beq) begin
          state_d = StFetch;
          retire  = 1'b1;
        end else if (is_lw || is_sw) begin
          state_d = StMem;
        end else begin
          state_d = StWb;
        end
      end
      StMem: begin
        if (mem_ready) begin
          if (is_sw) begin
            state_d = StFetch;
            retire  = 1'b1;
          end else begin
            state_d = StWb;
          end
        end
      end
      StWb: begin
        state_d = StFetch;
        retire  = 1'b1;
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  // Output decode of state and latched fields; everything held low while rst is asserted.
  always_comb begin
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_sel     = 1'b0;
    alu_src    = 1'b0;
    reg_dst    = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    if (!rst) begin
      unique case (state_q)
        StFetch: begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end
        StExec: begin
          if (is_beq) begin
            // Branch target is relative to the PC already bumped in FETCH.
            pc_sel   = 1'b1;
            pc_write = alu_zero;
          end else if (is_lw || is_sw) begin
            alu_src = 1'b1;
          end
        end
        StMem: begin
          if (is_lw) begin
            mem_read = 1'b1;
          end else if (is_sw) begin
            mem_write = 1'b1;
            alu_src   = 1'b1;
          end
        end
        StWb: begin
          if (is_rtype) begin
            reg_write = 1'b1;
            reg_dst   = 1'b1;
          end else if (is_lw) begin
            reg_write  = 1'b1;
            mem_to_reg = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mips_control_fsm.sv
// Self-checking bench for mips_control_fsm: directed sequences, a legality/latency table and
// randomized instruction streams checked against a per-instruction phase model.
module tb_mips_control_fsm;

  localparam int CNT_W = 2;

  // Expected control vectors, order {ir_write,pc_write,pc_sel,alu_src,reg_dst,reg_write,
  // mem_to_reg,mem_read,mem_write}.
  localparam logic [8:0] C_NONE   = 9'b000000000;
  localparam logic [8:0] C_FETCH  = 9'b110000000;
  localparam logic [8:0] C_EXEC_M = 9'b000100000;
  localparam logic [8:0] C_MEM_LW = 9'b000000010;
  localparam logic [8:0] C_MEM_SW = 9'b000100001;
  localparam logic [8:0] C_WB_R   = 9'b000011000;
  localparam logic [8:0] C_WB_LW  = 9'b000001100;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [5:0]       opcode = 6'd0;
  logic [5:0]       funct = 6'd0;
  logic             alu_zero = 1'b0;
  logic             mem_ready = 1'b0;
  logic             ir_write, pc_write, pc_sel, alu_src, reg_dst, reg_write;
  logic             mem_to_reg, mem_read, mem_write;
  logic [2:0]       state;
  logic             illegal;
  logic [CNT_W-1:0] instr_count;
  logic [8:0]       ctrl_vec;

  int n_checks = 0;
  int n_fail = 0;
  int exp_retired = 0;
  logic exp_illegal = 1'b0;

  typedef struct {
    logic [5:0] op;
    logic [5:0] fn;
    logic       az;
    int         waits;
    int         lat;
    logic       legal;
  } vec_t;

  vec_t tbl [12];

  mips_control_fsm #(.CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .opcode     (opcode),
    .funct      (funct),
    .alu_zero   (alu_zero),
    .mem_ready  (mem_ready),
    .ir_write   (ir_write),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .alu_src    (alu_src),
    .reg_dst    (reg_dst),
    .reg_write  (reg_write),
    .mem_to_reg (mem_to_reg),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .state      (state),
    .illegal    (illegal),
    .instr_count(instr_count)
  );

  assign ctrl_vec = {ir_write, pc_write, pc_sel, alu_src, reg_dst, reg_write, mem_to_reg,
                     mem_read, mem_write};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [5:0] r6();
    return 6'($urandom);
  endfunction

  function automatic logic r1();
    return 1'($urandom);
  endfunction

  function automatic logic [31:0] exp_count();
    return 32'(exp_retired % (1 << CNT_W));
  endfunction

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h", nm, act, req);
    end
  endtask

  // One clock cycle: drive inputs at the falling edge, then compare everything.
  task automatic cyc(input string nm, input logic [2:0] st, input logic [8:0] ctl,
                     input logic [5:0] op, input logic [5:0] fn, input logic az,
                     input logic mr);
    @(negedge clk);
    opcode    = op;
    funct     = fn;
    alu_zero  = az;
    mem_ready = mr;
    #1;
    check({nm, "_state"}, 32'(state), 32'(st));
    check({nm, "_ctrl"}, 32'(ctrl_vec), 32'(ctl));
    check({nm, "_illegal"}, 32'(illegal), 32'(exp_illegal));
    check({nm, "_count"}, 32'(instr_count), exp_count());
  endtask

  // Reference model: expands one instruction into its expected phase list.
  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input logic az,
                           input int waits);
    bit is_r, is_lw, is_sw, is_beq;
    is_r   = (op == 6'b000000) && (fn inside {6'b100000, 6'b100010, 6'b100100, 6'b100101});
    is_lw  = (op == 6'b100011);
    is_sw  = (op == 6'b101011);
    is_beq = (op == 6'b000100);
    cyc("fetch", 3'd0, C_FETCH, r6(), r6(), r1(), r1());
    cyc("decode", 3'd1, C_NONE, op, fn, r1(), r1());
    if (!(is_r || is_lw || is_sw || is_beq)) begin
      exp_illegal = 1'b1;
      return;
    end
    if (is_beq) begin
      cyc("exec_beq", 3'd2, {1'b0, az, 1'b1, 6'b0}, r6(), r6(), az, r1());
      exp_retired++;
      return;
    end
    if (is_r) begin
      cyc("exec_r", 3'd2, C_NONE, r6(), r6(), r1(), r1());
      cyc("wb_r", 3'd4, C_WB_R, r6(), r6(), r1(), r1());
      exp_retired++;
      return;
    end
    cyc("exec_mem", 3'd2, C_EXEC_M, r6(), r6(), r1(), r1());
    for (int i = 0; i < waits; i++) begin
      cyc("mem_wait", 3'd3, is_lw ? C_MEM_LW : C_MEM_SW, r6(), r6(), r1(), 1'b0);
    end
    cyc("mem_done", 3'd3, is_lw ? C_MEM_LW : C_MEM_SW, r6(), r6(), r1(), 1'b1);
    if (is_lw) begin
      cyc("wb_lw", 3'd4, C_WB_LW, r6(), r6(), r1(), r1());
    end
    exp_retired++;
  endtask

  task automatic halt_cycles(input int n);
    for (int i = 0; i < n; i++) begin
      cyc("halt", 3'd7, C_NONE, r6(), r6(), r1(), r1());
    end
  endtask

  // Synchronous-looking entry, but outputs are checked before any clock edge while rst is high.
  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    #1;
    exp_retired = 0;
    exp_illegal = 1'b0;
    check("rst_state", 32'(state), 32'd0);
    check("rst_ctrl", 32'(ctrl_vec), 32'd0);
    check("rst_illegal", 32'(illegal), 32'd0);
    check("rst_count", 32'(instr_count), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Steers one instruction from the DUT's own state and measures cycles until FETCH or HALT.
  task automatic measure(input vec_t v, output int lat);
    int left;
    left = v.waits;
    lat = 0;
    for (int i = 0; i < 30; i++) begin
      @(negedge clk);
      opcode    = (state == 3'd1) ? v.op : r6();
      funct     = (state == 3'd1) ? v.fn : r6();
      alu_zero  = (state == 3'd2) ? v.az : r1();
      mem_ready = (state == 3'd3) ? (left == 0) : r1();
      if (state == 3'd3 && left > 0) left--;
      lat++;
      @(posedge clk);
      #1;
      if (state == 3'd0 || state == 3'd7) break;
    end
  endtask

  initial begin
    logic [5:0] rfn [4];
    int lat;
    int k;
    logic [5:0] op, fn;

    rfn = '{6'b100000, 6'b100010, 6'b100100, 6'b100101};
    tbl[0]  = '{6'h00, 6'h20, 1'b0, 0, 4, 1'b1};
    tbl[1]  = '{6'h00, 6'h22, 1'b0, 0, 4, 1'b1};
    tbl[2]  = '{6'h00, 6'h24, 1'b1, 0, 4, 1'b1};
    tbl[3]  = '{6'h00, 6'h25, 1'b0, 0, 4, 1'b1};
    tbl[4]  = '{6'h23, 6'h00, 1'b0, 0, 5, 1'b1};
    tbl[5]  = '{6'h23, 6'h11, 1'b0, 3, 8, 1'b1};
    tbl[6]  = '{6'h2b, 6'h00, 1'b0, 0, 4, 1'b1};
    tbl[7]  = '{6'h2b, 6'h3f, 1'b0, 2, 6, 1'b1};
    tbl[8]  = '{6'h04, 6'h00, 1'b1, 0, 3, 1'b1};
    tbl[9]  = '{6'h04, 6'h00, 1'b0, 0, 3, 1'b1};
    tbl[10] = '{6'h02, 6'h00, 1'b0, 0, 2, 1'b0};
    tbl[11] = '{6'h00, 6'h2a, 1'b0, 0, 2, 1'b0};

    repeat (2) @(negedge clk);
    do_reset();

    // Directed sequences.
    run_instr(6'h00, 6'h20, 1'b0, 0);
    run_instr(6'h23, 6'h00, 1'b0, 3);
    run_instr(6'h04, 6'h00, 1'b1, 0);
    run_instr(6'h04, 6'h00, 1'b0, 0);
    run_instr(6'h2b, 6'h00, 1'b0, 0);
    run_instr(6'h02, 6'h00, 1'b0, 0);
    halt_cycles(20);
    do_reset();
    run_instr(6'h00, 6'h2a, 1'b0, 0);
    halt_cycles(20);
    do_reset();

    // Asynchronous reset in the middle of a lw memory wait.
    run_instr(6'h00, 6'h22, 1'b0, 0);
    cyc("mr_fetch", 3'd0, C_FETCH, r6(), r6(), r1(), r1());
    cyc("mr_decode", 3'd1, C_NONE, 6'h23, r6(), r1(), r1());
    cyc("mr_exec", 3'd2, C_EXEC_M, r6(), r6(), r1(), r1());
    cyc("mr_wait", 3'd3, C_MEM_LW, r6(), r6(), r1(), 1'b0);
    cyc("mr_wait", 3'd3, C_MEM_LW, r6(), r6(), r1(), 1'b0);
    rst = 1'b1;
    #1;
    exp_retired = 0;
    check("async_mem_read", 32'(mem_read), 32'd0);
    check("async_state", 32'(state), 32'd0);
    check("async_count", 32'(instr_count), 32'd0);
    check("async_ctrl", 32'(ctrl_vec), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;

    // Four retires wrap a 2-bit counter back to zero.
    run_instr(6'h00, 6'h25, 1'b0, 0);
    run_instr(6'h2b, 6'h00, 1'b0, 1);
    run_instr(6'h04, 6'h00, 1'b1, 0);
    run_instr(6'h23, 6'h00, 1'b0, 0);
    @(posedge clk);
    #1;
    check("wrap_count", 32'(instr_count), 32'd0);

    // Table: legality and latency measured from the DUT.
    do_reset();
    for (int i = 0; i < 12; i++) begin
      measure(tbl[i], lat);
      check($sformatf("tbl%0d_latency", i), 32'(lat), 32'(tbl[i].lat));
      check($sformatf("tbl%0d_illegal", i), 32'(illegal), 32'(!tbl[i].legal));
      if (tbl[i].legal) begin
        exp_retired++;
        check($sformatf("tbl%0d_count", i), 32'(instr_count), exp_count());
      end else begin
        do_reset();
      end
    end

    // Randomized instruction stream against the phase model.
    do_reset();
    for (int n = 0; n < 40; n++) begin
      k = $urandom_range(0, 7);
      fn = r6();
      unique case (k)
        0, 1: begin op = 6'h00; fn = rfn[$urandom_range(0, 3)]; end
        2: op = 6'h23;
        3: op = 6'h2b;
        4: op = 6'h04;
        5: op = 6'h00;
        default: op = r6();
      endcase
      run_instr(op, fn, r1(), $urandom_range(0, 3));
      if (exp_illegal) begin
        halt_cycles($urandom_range(1, 4));
        do_reset();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_control_fsm.md
# mips_control_fsm

Multi-cycle control unit for the 32-bit MIPS datapath. It sits directly downstream of the instruction splitter and directly upstream of the ALU, register file, data memory and PC adder. It consumes the decoded opcode/funct fields plus the ALU zero flag and sequences each instruction through fetch, decode, execute, memory and writeback. It drives every datapath strobe and mux select, and reports halt-on-illegal status and a retired-instruction count.

## Interface
- CNT_W, 16, width of retired-instruction counter (wraps)
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous reset, active-high
- opcode  in  6  opcode field from splitter; sampled only in DECODE
- funct  in  6  funct field from splitter; sampled only in DECODE
- alu_zero  in  1  high when ALU result == 32'h0; used only in EXEC of beq
- mem_ready  in  1  data memory done; qualifies the MEM state
- ir_write  out  1  latch instruction word
- pc_write  out  1  load PC from PC-adder output
- pc_sel  out  1  0: PC+1, 1: PC+sign-extended offset
- alu_src  out  1  0: in2=Rt, 1: in2=sign-extended imm
- reg_dst  out  1  0: write addr=rt, 1: write addr=rd
- reg_write  out  1  register file write enable
- mem_to_reg  out  1  0: write data=ALU result, 1: memory out
- mem_read  out  1  data memory read strobe
- mem_write  out  1  data memory write strobe
- state  out  3  current state encoding
- illegal  out  1  sticky; unsupported instruction decoded
- instr_count  out  CNT_W  retired instructions

## Operation
- Supported instructions:
  - R-type (opcode 000000) with funct 100000 add, 100010 sub, 100100 and, 100101 or.
  - lw (100011).
  - sw (101011).
  - beq (000100).
- State encoding: FETCH=0, DECODE=1, EXEC=2, MEM=3, WB=4, HALT=7.
- FETCH:
  - Outputs: ir_write=1, pc_write=1, pc_sel=0 (PC becomes PC+1, word-addressed).
  - Next state: DECODE.
- DECODE:
  - Latch opcode/funct into internal registers; all later states use only the latched copies.
  - Next state: EXEC if supported; otherwise HALT with illegal set.
- EXEC, R-type: alu_src=0. Next state: WB.
- EXEC, lw/sw: alu_src=1. Next state: MEM.
- EXEC, beq:
  - alu_src=0; pc_sel=1; pc_write=alu_zero. The branch target is relative to the already-incremented PC.
  - Retire; next state: FETCH.
- MEM, lw: mem_read=1. sw: mem_write=1, alu_src=1.
  - Stay in MEM while mem_ready=0; the strobe is held for the whole wait.
  - On mem_ready=1: lw goes to WB; sw retires and goes to FETCH.
- WB, R-type: reg_write=1, reg_dst=1, mem_to_reg=0. Retire; next state FETCH.
- WB, lw: reg_write=1, reg_dst=0, mem_to_reg=1. Retire; next state FETCH.
- HALT:
  - All strobes 0; illegal=1.
  - Remains in HALT until rst.
- Retire: instr_count += 1 on the clock edge leaving the last state of an instruction. Wraps from 2^CNT_W-1 to 0. Illegal instructions do not count.
- Unused outputs in any state are 0.

## Timing
- State register and counter update on the rising edge of clk.
- Control outputs are combinational decode of state and latched opcode/funct (Moore, except pc_write in beq EXEC, which follows alu_zero).
- Latency in cycles with mem_ready held high:
  - R-type: 4.
  - lw: 5.
  - sw: 4.
  - beq: 3.
  - Each cycle mem_ready is low in MEM adds one.
- Reset:
  - rst=1 asynchronously forces state=FETCH, illegal=0, instr_count=0 and the latched fields to 0.
  - While rst=1, all control outputs are forced to 0.
  - The first FETCH strobes occur in the cycle after rst deasserts.
- Reset mid-instruction (including during a MEM wait or in HALT) abandons the instruction with no retire and no further strobes.
- opcode/funct changes outside DECODE have no effect.
- mem_ready is ignored outside MEM.
- alu_zero is ignored outside beq EXEC.
- The counter wrap and a retire in the same edge produce 0.

## Test plan
- add (opcode 0, funct 100000) after reset -> state sequence 0,1,2,4,0. ir_write/pc_write high in cycle 1; reg_write=1, reg_dst=1 only in WB; instr_count=1.
- lw with mem_ready low for 3 cycles -> MEM held 4 cycles with mem_read=1 throughout; WB asserts reg_write=1, mem_to_reg=1, reg_dst=0; total 8 cycles; count +1.
- beq with alu_zero=1, then beq with alu_zero=0 -> first: pc_write=1, pc_sel=1 in EXEC; second: pc_write=0 in EXEC; each takes 3 cycles; count +2.
- sw with mem_ready=1 -> mem_write=1 and alu_src=1 for exactly 1 cycle; reg_write never asserted; back to FETCH after 4 cycles.
- opcode 000010 (unsupported) and R-type funct 101010 -> state=7, illegal=1, all strobes 0 for 20 cycles; instr_count unchanged; rst clears illegal and returns to FETCH.
- Assert rst asynchronously mid-MEM wait of lw -> mem_read drops immediately; state=0, instr_count=0; with CNT_W=2, 4 retires wrap count to 0.
